// File: rtl/selector_segmento_activacion.sv
// Segment selector for the piecewise-linear activation unit: 5-step binary search over a
// 32-entry breakpoint table, then fetch of slope/offset. Optional macro: SELSEG_EARLY_SAT_EN.
module selector_segmento_activacion #(
  parameter int Width     = 24,
  parameter int Magnitud  = 4,
  parameter int Precision = 19,
  parameter int Signo     = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    Start,
  input  logic signed [Width-1:0] In,
  input  logic                    WrEn,
  input  logic [1:0]              WrSel,
  input  logic [4:0]              WrAddr,
  input  logic signed [Width-1:0] WrData,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Enable,
  output logic [4:0]              SELMUX,
  output logic signed [Width-1:0] M,
  output logic signed [Width-1:0] B,
  output logic signed [Width-1:0] InReg,
  output logic                    Error
);

  if (Signo + Magnitud + Precision != Width) begin : g_format_check
    $error("selector_segmento_activacion: Signo+Magnitud+Precision must equal Width");
  end

  typedef enum logic [1:0] {IDLE, SEARCH, FETCH, DONE} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              sel_q, sel_d;
  logic [2:0]              bit_q, bit_d;
  logic signed [Width-1:0] inReg_q, inReg_d;
  logic [4:0]              selmux_q, selmux_d;
  logic signed [Width-1:0] m_q, m_d;
  logic signed [Width-1:0] b_q, b_d;
  logic                    enable_q, enable_d;
  logic                    error_q, error_d;
  logic [4:0]              cand;
  logic                    busy;

  logic signed [Width-1:0] bpTab [32];
  logic signed [Width-1:0] mTab  [32];
  logic signed [Width-1:0] bTab  [32];

  assign busy = (state_q == SEARCH) || (state_q == FETCH);

  // Tables are deliberately outside the reset domain so a reset keeps the programmed curve.
  always_ff @(posedge CLK) begin
    if (WrEn && !busy) begin
      case (WrSel)
        2'd0:    bpTab[WrAddr] <= WrData;
        2'd1:    mTab[WrAddr]  <= WrData;
        2'd2:    bTab[WrAddr]  <= WrData;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      bit_q    <= '0;
      inReg_q  <= '0;
      selmux_q <= '0;
      m_q      <= '0;
      b_q      <= '0;
      enable_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      bit_q    <= bit_d;
      inReg_q  <= inReg_d;
      selmux_q <= selmux_d;
      m_q      <= m_d;
      b_q      <= b_d;
      enable_q <= enable_d;
      error_q  <= error_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    bit_d    = bit_q;
    inReg_d  = inReg_q;
    selmux_d = selmux_q;
    m_d      = m_q;
    b_d      = b_q;
    enable_d = enable_q;
    error_d  = error_q;
    cand     = sel_q | (5'd1 << bit_q);

    if ((Start || WrEn) && busy) error_d = 1'b1;

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          inReg_d  = In;
          sel_d    = '0;
          bit_d    = 3'd4;
          enable_d = 1'b0;
          state_d  = SEARCH;
`ifdef SELSEG_EARLY_SAT_EN
          // Inputs outside the table range skip the search; the result is the same.
          if (In < bpTab[1]) begin
            sel_d   = 5'd0;
            state_d = FETCH;
          end else if (In >= bpTab[31]) begin
            sel_d   = 5'd31;
            state_d = FETCH;
          end
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (inReg_q >= bpTab[cand]) sel_d = cand;
        bit_d = bit_q - 3'd1;
        if (bit_q == 3'd0) state_d = FETCH;
      end
      FETCH: begin
        selmux_d = sel_q;
        m_d      = mTab[sel_q];
        b_d      = bTab[sel_q];
        enable_d = 1'b1;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy   = busy;
  assign Done   = (state_q == DONE);
  assign Enable = enable_q;
  assign SELMUX = selmux_q;
  assign M      = m_q;
  assign B      = b_q;
  assign InReg  = inReg_q;
  assign Error  = error_q;

endmodule
